jzjpcc_memory_stage_port: RTL and testbench
===========================================

# jzjpcc_memory_stage_port

Memory-stage load/store unit for the JZJ pipelined core; drives port B of the inferred SRAM, which is the data-side counterpart to the instruction fetch port A. It converts RV32I load/store requests into word-addressed SRAM accesses with byte write masks and byte-lane conversion. It splits misaligned accesses that cross a word boundary into two sequential SRAM accesses and stalls the pipeline while it does so. It returns sign- or zero-extended load data one cycle after the final SRAM access.

## Interface
- RAM_A_WIDTH, 12, SRAM word-address width; port B addresses `address[RAM_A_WIDTH+1:2]`.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- request_valid  in  1  memory-stage request present this cycle.
- request_write  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I width code: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- address  in  32  byte address; bits above RAM_A_WIDTH+1 are ignored.
- write_data  in  32  store value in native register order; the low bytes are used.
- stall  out  1  holds the pipeline; the request inputs must stay stable while stall is high.
- load_valid  out  1  load_data is valid this cycle.
- load_data  out  32  extended load result.
- illegal  out  1  combinational; funct3 is invalid for the request type; no SRAM write occurs.
- sram_addressB  out  RAM_A_WIDTH  SRAM word address.
- sram_writeEnableB  out  1  SRAM write strobe.
- sram_byteWriteMaskB  out  4  SRAM per-byte enables; bit j enables data bits [8j+7:8j].
- sram_writeB  out  32  SRAM write word.
- sram_readB  in  32  SRAM read word; synchronous read with 1-cycle latency.

## Operation
- Byte order: the byte at offset k (k = address[1:0] + lane) sits at SRAM bits [31-8k:24-8k] and is enabled by mask bit 3-k. Conversion uses the shared endianness functions.
- Size in bytes: 1 for B/BU, 2 for H/HU, 4 for W.
- An access crosses a word boundary when offset + size > 4: LH/SH at offset 3, or LW/SW at offsets 1, 2 or 3.
- FSM states:
  - IDLE.
  - SPLIT: second access of a crossing request.
- IDLE, no request or illegal: write enable 0, stall 0.
- IDLE, non-crossing request: a single access to word address[RAM_A_WIDTH+1:2]; state stays IDLE.
- IDLE, crossing request:
  - First access covers bytes offset..3 of word W; stall = 1; next state SPLIT.
  - A load registers the first-word bytes from sram_readB during the SPLIT cycle.
- SPLIT:
  - Second access covers bytes 0..(offset+size-5) of word W+1; stall = 0; next state IDLE.
  - W+1 wraps modulo 2^RAM_A_WIDTH, so the last word wraps to 0.
- Store masks:
  - Non-crossing: exactly size bits, starting at lane offset.
  - Crossing: the first and second masks are disjoint, their popcounts sum to size, and sram_writeB carries the write_data bytes shifted into the correct lanes.
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- illegal covers store funct3 ∉ {000,001,010} and load funct3 ∈ {011,110,111}. It never stalls and never asserts load_valid.

## Timing
- Non-crossing load requested in cycle N: load_valid = 1 in N+1.
- Non-crossing store requested in cycle N: the write commits at the clock edge ending cycle N.
- Crossing access requested in cycle N:
  - Cycle N: stall = 1.
  - Cycle N+1: second access in SPLIT.
  - Load: load_valid = 1 in N+2.
  - Store: the two writes commit at the edges ending N and N+1.
- load_valid is a 1-cycle pulse.
- A new request may be presented in the same cycle that load_valid is asserted.
- Reset values: state IDLE, load_valid 0, load_data 0, latched first-word bytes 0. The combinational outputs stall = 0 and write enable = 0 follow from IDLE.
- Reset asserted during SPLIT aborts the access: no second write occurs and no load_valid is produced.
- Request inputs changing while stall = 1 is illegal stimulus; the behaviour is unspecified.

## Structure
- A new shared package, jzjpcc_memory_stage_types, holds:
  - the funct3 enum;
  - the FSM state typedef (IDLE, SPLIT);
  - a function returning size from funct3.
- Byte-swap functions are reused from jzjpcc_endianness_functions.
- Sub-module jzjpcc_lane_aligner (combinational) provides:
  - store lane shift and mask generation for the first and second access;
  - load byte gather and extension.
- The top level holds the FSM, the latched first-word bytes, the load-info pipeline register (funct3, offset) and the load_valid register.

## Test plan
- SW 0xDEADBEEF to address 0x10, then LW 0x10 → mask 1111 on word 4; in the following cycle load_valid = 1 and load_data = 0xDEADBEEF.
- SB 0x80 to address 0x13, then LB 0x13 → mask 0001; load_data = 0xFFFFFF80. LBU 0x13 → load_data = 0x00000080.
- SW 0x11223344 to address 0x21 → stall for 1 cycle; word 8 mask 0111, then word 9 mask 1000.
  - Follow with LW 0x21 → stall for 1 cycle; load_data = 0x11223344, valid two cycles after the request.
- SH 0xABCD to the last byte of memory (word 2^RAM_A_WIDTH−1, offset 3) → second write goes to word 0 with mask 1000.
  - Follow with LHU of the same address → load_data = 0x0000ABCD.
- Assert reset during SPLIT of an SW to 0x22 → word 9 is unchanged, load_valid stays 0, and the FSM is in IDLE.
- Store with funct3 = 011 → illegal = 1, sram_writeEnableB = 0, stall = 0.

Source files
------------

// File: rtl/jzjpcc_endianness_functions.sv
// Byte-order helpers between register (little-endian) order and SRAM order,
// where byte offset 0 lives in the most significant lane.
package jzjpcc_endianness_functions;

  function automatic logic [31:0] swap_bytes32(input logic [31:0] w);
    swap_bytes32 = {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [3:0] swap_mask4(input logic [3:0] m);
    swap_mask4 = {m[0], m[1], m[2], m[3]};
  endfunction

endpackage

// File: rtl/jzjpcc_memory_stage_types.sv
// Shared types for the memory-stage port: RV32I width codes, FSM states and
// the access-size helper.
package jzjpcc_memory_stage_types;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  function automatic logic [2:0] access_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: access_size = 3'd1;
      F3_H, F3_HU: access_size = 3'd2;
      default:     access_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/jzjpcc_lane_aligner.sv
// Combinational lane steering: store shift/mask for both halves of a split
// access, and load byte gather with sign/zero extension.
module jzjpcc_lane_aligner
  import jzjpcc_memory_stage_types::*;
  import jzjpcc_endianness_functions::*;
(
  input  logic [1:0]  st_offset,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] write_data,
  output logic [31:0] st_first_word,
  output logic [31:0] st_second_word,
  output logic [3:0]  st_first_mask,
  output logic [3:0]  st_second_mask,
  input  logic [1:0]  ld_offset,
  input  logic [2:0]  ld_funct3,
  input  logic [31:0] ld_first_word,
  input  logic [31:0] ld_second_word,
  output logic [31:0] ld_result
);

  logic [3:0]  st_size_mask;
  logic [63:0] st_wide;
  logic [7:0]  st_mask_wide;
  logic [63:0] ld_wide;
  logic [31:0] ld_shifted;

  function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [2:0] f3);
    case (f3)
      F3_B:    extend_load = {{24{d[7]}}, d[7:0]};
      F3_H:    extend_load = {{16{d[15]}}, d[15:0]};
      F3_BU:   extend_load = {24'd0, d[7:0]};
      F3_HU:   extend_load = {16'd0, d[15:0]};
      default: extend_load = d;
    endcase
  endfunction

  // Work in little-endian order across a two-word window, then convert lanes.
  always_comb begin
    case (st_funct3)
      F3_B, F3_BU: st_size_mask = 4'b0001;
      F3_H, F3_HU: st_size_mask = 4'b0011;
      default:     st_size_mask = 4'b1111;
    endcase
    st_wide        = {32'd0, write_data} << {st_offset, 3'b000};
    st_mask_wide   = {4'd0, st_size_mask} << st_offset;
    st_first_word  = swap_bytes32(st_wide[31:0]);
    st_second_word = swap_bytes32(st_wide[63:32]);
    st_first_mask  = swap_mask4(st_mask_wide[3:0]);
    st_second_mask = swap_mask4(st_mask_wide[7:4]);

    ld_wide    = {swap_bytes32(ld_second_word), swap_bytes32(ld_first_word)} >> {ld_offset, 3'b000};
    ld_shifted = ld_wide[31:0];
    ld_result  = extend_load(ld_shifted, ld_funct3);
  end

endmodule

// File: rtl/jzjpcc_memory_stage_port.sv
// Memory-stage load/store unit driving SRAM port B; splits word-crossing
// accesses into two cycles and returns extended load data one cycle later.
module jzjpcc_memory_stage_port
  import jzjpcc_memory_stage_types::*;
#(
  parameter int RAM_A_WIDTH = 12
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   request_valid,
  input  logic                   request_write,
  input  logic [2:0]             funct3,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic                   stall,
  output logic                   load_valid,
  output logic [31:0]            load_data,
  output logic                   illegal,
  output logic [RAM_A_WIDTH-1:0] sram_addressB,
  output logic                   sram_writeEnableB,
  output logic [3:0]             sram_byteWriteMaskB,
  output logic [31:0]            sram_writeB,
  input  logic [31:0]            sram_readB
);

  state_t                 state;
  logic [1:0]             offset_p0;
  logic [RAM_A_WIDTH-1:0] word_p0;
  logic [2:0]             size_p0;
  logic                   crossing_p0;
  logic                   active_p0;
  logic                   in_split;
  logic                   ld_issue_p0;
  logic [31:0]            st_first_word, st_second_word;
  logic [3:0]             st_first_mask, st_second_mask;
  logic [31:0]            ld_result;
  logic                   unused_addr_bits;

  logic                   vld_p1;
  logic [2:0]             ld_funct3_p1;
  logic [1:0]             ld_offset_p1;
  logic                   ld_cross_p1;
  logic [31:0]            first_bytes_p1;

  // Request decode (p0)
  assign offset_p0        = address[1:0];
  assign word_p0          = address[RAM_A_WIDTH+1:2];
  assign unused_addr_bits = ^address[31:RAM_A_WIDTH+2];
  assign size_p0          = access_size(funct3);
  assign crossing_p0      = ({1'b0, offset_p0} + size_p0) > 3'd4;
  assign illegal          = request_valid &&
                            (request_write ? !(funct3 inside {3'b000, 3'b001, 3'b010})
                                           :  (funct3 inside {3'b011, 3'b110, 3'b111}));
  assign active_p0        = request_valid && !illegal;
  assign in_split         = (state == SPLIT);
  assign stall            = !in_split && active_p0 && crossing_p0;
  assign ld_issue_p0      = active_p0 && !request_write && (in_split || !crossing_p0);

  assign sram_addressB       = in_split ? word_p0 + RAM_A_WIDTH'(1) : word_p0;
  assign sram_writeEnableB   = active_p0 && request_write;
  assign sram_byteWriteMaskB = sram_writeEnableB ? (in_split ? st_second_mask : st_first_mask) : 4'd0;
  assign sram_writeB         = in_split ? st_second_word : st_first_word;

  jzjpcc_lane_aligner u_lane_aligner (
    .st_offset      (offset_p0),
    .st_funct3      (funct3),
    .write_data     (write_data),
    .st_first_word  (st_first_word),
    .st_second_word (st_second_word),
    .st_first_mask  (st_first_mask),
    .st_second_mask (st_second_mask),
    .ld_offset      (ld_offset_p1),
    .ld_funct3      (ld_funct3_p1),
    .ld_first_word  (ld_cross_p1 ? first_bytes_p1 : sram_readB),
    .ld_second_word (sram_readB),
    .ld_result      (ld_result)
  );

  // FSM and load-return pipeline (p1)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      vld_p1         <= 1'b0;
      ld_funct3_p1   <= 3'd0;
      ld_offset_p1   <= 2'd0;
      ld_cross_p1    <= 1'b0;
      first_bytes_p1 <= 32'd0;
    end else begin
      case (state)
        IDLE:    state <= stall ? SPLIT : IDLE;
        default: state <= IDLE;
      endcase
      vld_p1 <= ld_issue_p0;
      if (ld_issue_p0) begin
        ld_funct3_p1 <= funct3;
        ld_offset_p1 <= offset_p0;
        ld_cross_p1  <= in_split;
      end
      if (in_split && !request_write)
        first_bytes_p1 <= sram_readB;
    end
  end

  assign load_valid = vld_p1;
  assign load_data  = vld_p1 ? ld_result : 32'd0;

endmodule

// File: tb/tb_jzjpcc_memory_stage_port.sv
// Directed bench with a byte-masked SRAM model and a load-return scoreboard.
module tb_jzjpcc_memory_stage_port;

  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          request_valid = 1'b0;
  logic          request_write = 1'b0;
  logic [2:0]    funct3 = 3'd0;
  logic [31:0]   address = 32'd0;
  logic [31:0]   write_data = 32'd0;
  logic          stall, load_valid, illegal;
  logic [31:0]   load_data;
  logic [AW-1:0] sram_addressB;
  logic          sram_writeEnableB;
  logic [3:0]    sram_byteWriteMaskB;
  logic [31:0]   sram_writeB;
  logic [31:0]   sram_readB;

  always #5 clock = ~clock;

  jzjpcc_memory_stage_port #(.RAM_A_WIDTH(AW)) dut (
    .clock               (clock),
    .reset               (reset),
    .request_valid       (request_valid),
    .request_write       (request_write),
    .funct3              (funct3),
    .address             (address),
    .write_data          (write_data),
    .stall               (stall),
    .load_valid          (load_valid),
    .load_data           (load_data),
    .illegal             (illegal),
    .sram_addressB       (sram_addressB),
    .sram_writeEnableB   (sram_writeEnableB),
    .sram_byteWriteMaskB (sram_byteWriteMaskB),
    .sram_writeB         (sram_writeB),
    .sram_readB          (sram_readB)
  );

  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] rd_q;
  always @(posedge clock) begin
    if (sram_writeEnableB)
      for (int j = 0; j < 4; j++)
        if (sram_byteWriteMaskB[j]) mem[sram_addressB][8*j +: 8] <= sram_writeB[8*j +: 8];
    rd_q <= mem[sram_addressB];
  end
  assign sram_readB = rd_q;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset && load_valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_load_valid: got data %h expected no load", load_data);
      end else begin
        mon_e = sbq.pop_front();
        chk("load_data", load_data, mon_e.data);
        chk("load_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  task automatic req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    request_valid = 1'b1;
    request_write = w;
    funct3        = f3;
    address       = a;
    write_data    = d;
    #1;
  endtask

  task automatic expect_load(input logic [31:0] d, input int lat);
    exp_t e;
    e.data = d;
    e.due  = cyc + lat;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic idle();
    @(negedge clock);
    request_valid = 1'b0;
    request_write = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_load_valid", {31'd0, load_valid}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_we", {31'd0, sram_writeEnableB}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Clear words 8 and 9 so later whole-word memory checks are exact.
    req(1'b1, 3'b010, 32'h20, 32'h0);
    chk("clr8_addr", 32'(sram_addressB), 32'd8);
    req(1'b1, 3'b010, 32'h24, 32'h0);

    req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    chk("sw10_we", {31'd0, sram_writeEnableB}, 32'd1);
    chk("sw10_mask", {28'd0, sram_byteWriteMaskB}, 32'hF);
    chk("sw10_addr", 32'(sram_addressB), 32'd4);
    chk("sw10_wdata", sram_writeB, 32'hEFBEADDE);
    chk("sw10_stall", {31'd0, stall}, 32'd0);
    req(1'b0, 3'b010, 32'h10, 32'h0);
    expect_load(32'hDEADBEEF, 1);
    chk("lw10_we", {31'd0, sram_writeEnableB}, 32'd0);

    req(1'b1, 3'b000, 32'h13, 32'h80);
    chk("sb13_mask", {28'd0, sram_byteWriteMaskB}, 32'h1);
    chk("sb13_wdata", sram_writeB, 32'h00000080);
    req(1'b0, 3'b000, 32'h13, 32'h0);
    expect_load(32'hFFFFFF80, 1);
    req(1'b0, 3'b100, 32'h13, 32'h0);
    expect_load(32'h00000080, 1);

    req(1'b1, 3'b010, 32'h21, 32'h11223344);
    chk("sw21_a_stall", {31'd0, stall}, 32'd1);
    chk("sw21_a_addr", 32'(sram_addressB), 32'd8);
    chk("sw21_a_mask", {28'd0, sram_byteWriteMaskB}, 32'h7);
    chk("sw21_a_wdata", sram_writeB, 32'h00443322);
    step();
    chk("sw21_b_stall", {31'd0, stall}, 32'd0);
    chk("sw21_b_addr", 32'(sram_addressB), 32'd9);
    chk("sw21_b_mask", {28'd0, sram_byteWriteMaskB}, 32'h8);
    chk("sw21_b_wdata", sram_writeB, 32'h11000000);
    req(1'b0, 3'b010, 32'h21, 32'h0);
    expect_load(32'h11223344, 2);
    chk("lw21_a_stall", {31'd0, stall}, 32'd1);
    chk("mem8_after_sw21", mem[8], 32'h00443322);
    chk("mem9_after_sw21", mem[9], 32'h11000000);
    step();
    chk("lw21_b_stall", {31'd0, stall}, 32'd0);
    chk("lw21_b_addr", 32'(sram_addressB), 32'd9);

    req(1'b1, 3'b001, 32'h00003FFF, 32'h0000ABCD);
    chk("sh_last_a_addr", 32'(sram_addressB), 32'hFFF);
    chk("sh_last_a_mask", {28'd0, sram_byteWriteMaskB}, 32'h1);
    chk("sh_last_a_wdata", sram_writeB, 32'h000000CD);
    step();
    chk("sh_last_b_addr", 32'(sram_addressB), 32'd0);
    chk("sh_last_b_mask", {28'd0, sram_byteWriteMaskB}, 32'h8);
    chk("sh_last_b_wdata", sram_writeB, 32'hAB000000);
    req(1'b0, 3'b101, 32'h00003FFF, 32'h0);
    expect_load(32'h0000ABCD, 2);
    step();
    req(1'b0, 3'b001, 32'h00003FFF, 32'h0);
    expect_load(32'hFFFFABCD, 2);
    step();

    req(1'b1, 3'b011, 32'h10, 32'h12345678);
    chk("ill_st_illegal", {31'd0, illegal}, 32'd1);
    chk("ill_st_we", {31'd0, sram_writeEnableB}, 32'd0);
    chk("ill_st_stall", {31'd0, stall}, 32'd0);
    req(1'b0, 3'b110, 32'h21, 32'h0);
    chk("ill_ld_illegal", {31'd0, illegal}, 32'd1);
    chk("ill_ld_stall", {31'd0, stall}, 32'd0);
    idle();
    chk("idle_illegal", {31'd0, illegal}, 32'd0);
    chk("mem4_bytes", mem[4], 32'hEFBEAD80);

    // Abort a split store: first half lands in word 8, word 9 must survive.
    req(1'b1, 3'b010, 32'h22, 32'hCAFEF00D);
    chk("sw22_stall", {31'd0, stall}, 32'd1);
    @(posedge clock);
    #2;
    chk("sw22_split_addr", 32'(sram_addressB), 32'd9);
    reset = 1'b0;
    #1;
    chk("sw22_rst_idle_stall", {31'd0, stall}, 32'd1);
    chk("sw22_rst_idle_addr", 32'(sram_addressB), 32'd8);
    request_valid = 1'b0;
    #1;
    chk("sw22_rst_we", {31'd0, sram_writeEnableB}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    idle();
    idle();
    chk("sw22_mem9_unchanged", mem[9], 32'h11000000);
    chk("sw22_mem8_first_half", mem[8], 32'h00440DF0);
    chk("sw22_load_valid", {31'd0, load_valid}, 32'd0);

    repeat (4) idle();
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
